sprite_blit_writer: RTL and testbench
=====================================

# sprite_blit_writer

Copies one 55x55 4-bit palette-indexed sprite from its sprite ROM into the 640x480 4-bit framebuffer RAM at a requested screen offset. It is the write-side counterpart of the per-pixel sprite readers: those fetch sprite ROM pixels during scan-out, while this block streams the ROM into the framebuffer once per piece move. It skips transparent pixels, clips at the screen edges, and reports completion with a start/busy/done handshake to the game controller.

## Interface
- SPR_W, 55: sprite width in pixels
- SPR_H, 55: sprite height in pixels
- SCR_W, 640: framebuffer width
- SCR_H, 480: framebuffer height
- TRANSPARENT_IDX, 0: palette index that is never written

- vga_clk  input  1  sole clock, all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a blit, sampled in IDLE only
- dstX  input  10  screen X of sprite pixel (0,0), latched on start
- dstY  input  10  screen Y of sprite pixel (0,0), latched on start
- rom_address  output  12  sprite ROM address = y*SPR_W + x
- rom_q  input  4  sprite ROM data, valid one cycle after rom_address
- fb_we  output  1  framebuffer write enable, one pixel per cycle
- fb_addr  output  19  framebuffer address = Y*SCR_W + X
- fb_data  output  4  palette index written
- busy  output  1  blit in progress
- done  output  1  one-cycle pulse at end of blit

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches dstX/dstY, clears x,y counters, moves to RUN. start=0 keeps the block in IDLE.
- RUN: rom_address = y*SPR_W + x. x increments each cycle. It wraps to 0 at SPR_W-1 and y increments on the wrap. After address SPR_W*SPR_H-1 (3024), the state moves to DRAIN.
- DRAIN: 2 cycles to flush the pipeline, then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start in RUN, DRAIN, or DONE is ignored. It is not queued.
- Pipeline carries x, y, and a valid bit alongside each address. Stage 1 presents the address. Stage 2 receives rom_q. Stage 3 registers fb_we, fb_addr, and fb_data.
- Screen coordinates: X = dstX + x and Y = dstY + y, computed 11 bits wide, no wrap.
- fb_we = valid AND rom_q != TRANSPARENT_IDX AND X < SCR_W AND Y < SCR_H.
- fb_addr = Y*SCR_W + X, 19 bits. It is computed only for in-screen pixels and is 0 when fb_we=0.
- fb_data = rom_q when fb_we=1, else 0.
- Reset values: state IDLE; rom_address 0; fb_we 0; fb_addr 0; fb_data 0; busy 0; done 0; counters and pipeline valid bits 0.
- Reset mid-blit aborts immediately with no further writes. The next start restarts from address 0.

## Timing
- Cycle 0 is the first RUN cycle, one cycle after the edge that samples start.
- rom_address = n in cycle n, for n = 0..3024.
- rom_q for pixel n is valid in cycle n+1.
- fb_we, fb_addr, and fb_data for pixel n are visible in cycle n+2. Last possible write is in cycle 3026.
- done=1 in cycle 3027. The block is in IDLE from cycle 3028, and start is accepted there.
- busy=1 in cycles 0..3027 inclusive. busy=0 in IDLE.
- Throughput is one pixel per cycle, with no stalls. The framebuffer port accepts a write every cycle.
- Minimum start-to-start interval is 3029 cycles.

## Test plan
- Reset: hold reset_n=0 with start=1 and rom_q=0xF. All outputs read 0. Release reset with start=0. The block stays idle with busy=0.
- Full blit at (0,0), ROM all 5: exactly 3025 writes with fb_data=5. First write is fb_addr=0 in cycle 2. Pixel (54,0) writes fb_addr=54. Pixel (0,1) writes fb_addr=640. Last write is fb_addr=34614 in cycle 3026. done is in cycle 3027.
- Transparency: ROM = index 0 where x is even, else 3; dst (100,50). Only odd-x pixels are written, 27*55=1485 writes. Pixel (1,0) writes fb_addr=32101 with data 3.
- Clipping: dst (600,450), ROM all 7. Writes only for x<40 and y<30, 1200 writes. No fb_addr reaches or exceeds 307200. done still arrives in cycle 3027.
- Handshake: start pulses in cycles 10, 3026, and 3027 are ignored, with no restart and no extra done. A start in cycle 3028 begins a new blit with rom_address=0 in cycle 3029.
- Reset mid-blit: assert reset_n=0 in cycle 1500. fb_we=0 and busy=0 within the same cycle. After release, start at (0,0) writes fb_addr=0 first.

Source files
------------

// File: rtl/sprite_blit_writer_if.sv
// Blit request, sprite ROM and framebuffer write bundle.
// The controller/memory side is the master; the blitter is the slave.
interface sprite_blit_writer_if;
  logic        start;
  logic [9:0]  dstX;
  logic [9:0]  dstY;
  logic [11:0] rom_address;
  logic [3:0]  rom_q;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        busy;
  logic        done;

  modport master (
    output start, dstX, dstY, rom_q,
    input  rom_address, fb_we, fb_addr,
    input  fb_data, busy, done
  );

  modport slave (
    input  start, dstX, dstY, rom_q,
    output rom_address, fb_we, fb_addr,
    output fb_data, busy, done
  );
endinterface

// File: rtl/sprite_blit_writer.sv
// Streams one sprite ROM into the framebuffer at (dstX,dstY),
// skipping transparent pixels and clipping at the screen edge.
module sprite_blit_writer #(
  parameter int         SPR_W = 55,
  parameter int         SPR_H = 55,
  parameter int         SCR_W = 640,
  parameter int         SCR_H = 480,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
  input logic                 vga_clk,
  input logic                 reset_n,
  sprite_blit_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [11:0] LAST  = 12'(SPR_W * SPR_H - 1);
  localparam logic [5:0]  XLAST = 6'(SPR_W - 1);

  state_t r_state;
  state_t w_next;

  logic [9:0]  r_dx;
  logic [9:0]  r_dy;
  logic [5:0]  r_x;
  logic [5:0]  r_y;
  logic [11:0] r_addr;
  logic        r_drn;

  logic        r_v2;
  logic [5:0]  r_x2;
  logic [5:0]  r_y2;

  logic        r_we;
  logic [18:0] r_fa;
  logic [3:0]  r_fd;

  logic        w_run;
  logic [10:0] w_sx;
  logic [10:0] w_sy;
  logic        w_in;
  logic        w_we;
  logic [18:0] w_fa;

  assign w_run = (r_state == S_RUN);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_addr == LAST) w_next = S_DRAIN;
      S_DRAIN: if (r_drn) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stage 2: rom_q arrives alongside the coordinates of its address
  assign w_sx = {1'b0, r_dx} + {5'b0, r_x2};
  assign w_sy = {1'b0, r_dy} + {5'b0, r_y2};
  assign w_in = (w_sx < 11'(SCR_W)) && (w_sy < 11'(SCR_H));
  assign w_we = r_v2 && (bus.rom_q != TRANSPARENT_IDX) && w_in;
  assign w_fa = 19'(w_sy) * 19'(SCR_W) + 19'(w_sx);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dx   <= '0;
      r_dy   <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_drn  <= 1'b0;
      r_v2   <= 1'b0;
      r_x2   <= '0;
      r_y2   <= '0;
      r_we   <= 1'b0;
      r_fa   <= '0;
      r_fd   <= '0;
    end else begin
      r_v2 <= w_run;
      r_x2 <= r_x;
      r_y2 <= r_y;
      r_we <= w_we;
      r_fa <= w_we ? w_fa : 19'd0;
      r_fd <= w_we ? bus.rom_q : 4'd0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dx   <= bus.dstX;
            r_dy   <= bus.dstY;
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
          end
        end
        S_RUN: begin
          r_drn <= 1'b0;
          if (r_addr != LAST) r_addr <= r_addr + 12'd1;
          if (r_x == XLAST) begin
            r_x <= '0;
            r_y <= r_y + 6'd1;
          end else begin
            r_x <= r_x + 6'd1;
          end
        end
        S_DRAIN: r_drn <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rom_address = r_addr;
  assign bus.fb_we       = r_we;
  assign bus.fb_addr     = r_fa;
  assign bus.fb_data     = r_fd;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);

endmodule

// File: tb/tb_sprite_blit_writer.sv
// Scoreboard bench for sprite_blit_writer: expected writes queued
// from a ROM model, popped as the DUT writes the framebuffer.
module tb_sprite_blit_writer;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  int   mode = 3;
  exp_t q[$];

  always #5 clk = ~clk;

  sprite_blit_writer_if bus ();

  sprite_blit_writer dut (
    .vga_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int romf(int m, int a);
    int x;
    x = a % 55;
    case (m)
      0:       return 5;
      1:       return (x % 2 == 0) ? 0 : 3;
      2:       return 7;
      default: return 15;
    endcase
  endfunction

  always @(posedge clk)
    bus.rom_q <= 4'(romf(mode, int'(bus.rom_address)));

  task automatic run_blit(int dx, int dy, int m, bit hs,
                          int abort_at, int nexp);
    int   nw;
    int   maxa;
    int   sx;
    int   sy;
    int   d;
    exp_t e;
    nw = 0;
    maxa = 0;
    q.delete();
    for (int y = 0; y < 55; y++) begin
      for (int x = 0; x < 55; x++) begin
        sx = dx + x;
        sy = dy + y;
        d  = romf(m, y * 55 + x);
        if (d != 0 && sx < 640 && sy < 480)
          q.push_back('{sy * 640 + sx, d, y * 55 + x + 2});
      end
    end
    mode = m;
    bus.dstX = 10'(dx);
    bus.dstY = 10'(dy);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 3028; c++) begin
      @(negedge clk);
      bus.start = hs && (c == 10 || c == 3026 || c == 3027);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_we", bus.fb_we, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_addr", bus.fb_addr, 0);
        @(negedge clk);
        check("abort_hold_we", bus.fb_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        return;
      end
      if (c <= 3024) check("rom_addr", bus.rom_address, c);
      check("busy", bus.busy, c <= 3027);
      check("done", bus.done, c == 3027);
      if (bus.fb_we) begin
        nw++;
        if (int'(bus.fb_addr) > maxa) maxa = int'(bus.fb_addr);
        check("write_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("fb_addr", bus.fb_addr, e.addr);
          check("fb_data", bus.fb_data, e.data);
          check("fb_cycle", c, e.cyc);
        end
      end else begin
        check("idle_fb_addr", bus.fb_addr, 0);
        check("idle_fb_data", bus.fb_data, 0);
      end
    end
    check("missing_writes", q.size(), 0);
    check("write_count", nw, nexp);
    check("addr_in_fb", maxa < 307200, 1);
  endtask

  initial begin
    bus.start = 1'b1;
    bus.dstX = 10'd0;
    bus.dstY = 10'd0;
    mode = 3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fb_we", bus.fb_we, 0);
    check("rst_fb_addr", bus.fb_addr, 0);
    check("rst_fb_data", bus.fb_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rom_addr", bus.rom_address, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_done", bus.done, 0);
    check("idle_we", bus.fb_we, 0);

    run_blit(0, 0, 0, 1'b0, -1, 3025);
    run_blit(100, 50, 1, 1'b0, -1, 1485);
    run_blit(600, 450, 2, 1'b1, -1, 1200);
    run_blit(0, 0, 0, 1'b0, -1, 3025);
    run_blit(0, 0, 0, 1'b0, 1500, 0);
    run_blit(0, 0, 0, 1'b0, -1, 3025);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
